// File: rtl/rom_boot_loader_pkg.sv
// Shared definitions for the ROM boot loader: FSM encoding, frame constants
// and a helper that tells whether a state belongs to an active frame.
package rom_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;
  localparam int         LEN_BYTES     = 4;
  localparam int         WORD_BYTES    = 4;

  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/rom_boot_loader_timer.sv
// Inter-byte timeout counter: counts while enabled, clears on request,
// flags expiry when the count reaches TIMEOUT_CYCLES-1.
module boot_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  assign expired = en && (count_reg == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (clr || !en) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rom_boot_loader.sv
// Loads a checksummed byte-stream image into the instruction ROM and holds
// the core in reset until the whole image has been written and verified.
module rom_boot_loader
  import rom_boot_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 12,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] MAGIC          = DEFAULT_MAGIC,
  parameter bit         BOOT_BYPASS    = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        boot_req,
  output logic        rom_we,
  output logic [31:0] rom_waddr,
  output logic [31:0] rom_wdata,
  output logic        core_rstn,
  output logic        load_done,
  output logic        load_err,
  output logic        busy
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;
  localparam logic [1:0]  LEN_LAST  = 2'(LEN_BYTES - 1);
  localparam logic [1:0]  WORD_LAST = 2'(WORD_BYTES - 1);

  state_t              state_reg;
  logic [1:0]          byte_cnt_reg;
  logic [ADDR_WIDTH:0] word_idx_reg;
  logic [ADDR_WIDTH:0] n_words_reg;
  logic [7:0]          csum_reg;
  logic [23:0]         shift_reg;
  logic [31:0]         shift_next;
  logic                len_bad;
  logic                expired;

  // Bytes arrive little-endian, so each new byte enters at the top.
  assign shift_next = {rx_data, shift_reg};
  assign len_bad    = (shift_next == 32'd0) || ({1'b0, shift_next} > MAX_WORDS);
  assign busy       = in_frame(state_reg);

  boot_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (rx_valid | boot_req),
    .en     (in_frame(state_reg)),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      byte_cnt_reg <= '0;
      word_idx_reg <= '0;
      n_words_reg  <= '0;
      csum_reg     <= '0;
      shift_reg    <= '0;
      rom_we       <= 1'b0;
      rom_waddr    <= '0;
      rom_wdata    <= '0;
      core_rstn    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      if (BOOT_BYPASS) begin
        state_reg <= ST_DONE;
        load_done <= 1'b1;
        core_rstn <= 1'b1;
      end else if (boot_req) begin
        // Abort takes priority over any byte arriving in the same cycle.
        state_reg    <= ST_IDLE;
        byte_cnt_reg <= '0;
        core_rstn    <= 1'b0;
        load_done    <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (rx_valid && rx_data == MAGIC) begin
              state_reg    <= ST_LEN;
              load_err     <= 1'b0;
              csum_reg     <= '0;
              byte_cnt_reg <= '0;
            end
          end
          ST_LEN: begin
            if (rx_valid) begin
              csum_reg     <= csum_reg ^ rx_data;
              shift_reg    <= shift_next[31:8];
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
              if (byte_cnt_reg == LEN_LAST) begin
                byte_cnt_reg <= '0;
                word_idx_reg <= '0;
                n_words_reg  <= shift_next[ADDR_WIDTH:0];
                if (len_bad) begin
                  state_reg <= ST_ERR;
                  load_err  <= 1'b1;
                end else begin
                  state_reg <= ST_DATA;
                end
              end
            end else if (expired) begin
              state_reg <= ST_ERR;
              load_err  <= 1'b1;
            end
          end
          ST_DATA: begin
            if (rx_valid) begin
              csum_reg     <= csum_reg ^ rx_data;
              shift_reg    <= shift_next[31:8];
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
              if (byte_cnt_reg == WORD_LAST) begin
                byte_cnt_reg <= '0;
                rom_we       <= 1'b1;
                rom_waddr    <= 32'(word_idx_reg) << 2;
                rom_wdata    <= shift_next;
                word_idx_reg <= word_idx_reg + 1'b1;
                if (word_idx_reg == n_words_reg - 1'b1) begin
                  state_reg <= ST_CSUM;
                end
              end
            end else if (expired) begin
              state_reg <= ST_ERR;
              load_err  <= 1'b1;
            end
          end
          ST_CSUM: begin
            if (rx_valid) begin
              if (rx_data == csum_reg) begin
                state_reg <= ST_DONE;
                load_done <= 1'b1;
              end else begin
                state_reg <= ST_ERR;
                load_err  <= 1'b1;
              end
            end else if (expired) begin
              state_reg <= ST_ERR;
              load_err  <= 1'b1;
            end
          end
          ST_DONE: begin
            core_rstn <= 1'b1;
          end
          ST_ERR: begin
            state_reg <= ST_IDLE;
            core_rstn <= 1'b0;
            load_done <= 1'b0;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: table of frames plus hand-written sequences for
// timeout, boot_req and mid-frame reset; ROM writes go through a scoreboard.
module tb_rom_boot_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        boot_req = 1'b0;
  logic        rom_we;
  logic [31:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        core_rstn;
  logic        load_done;
  logic        load_err;
  logic        busy;

  logic        byp_rom_we;
  logic [31:0] byp_rom_waddr;
  logic [31:0] byp_rom_wdata;
  logic        byp_core_rstn;
  logic        byp_load_done;
  logic        byp_load_err;
  logic        byp_busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  rom_boot_loader #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .boot_req(boot_req), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .core_rstn(core_rstn), .load_done(load_done),
    .load_err(load_err), .busy(busy)
  );

  rom_boot_loader #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(100), .BOOT_BYPASS(1'b1)) dut_byp (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .boot_req(boot_req), .rom_we(byp_rom_we), .rom_waddr(byp_rom_waddr),
    .rom_wdata(byp_rom_wdata), .core_rstn(byp_core_rstn), .load_done(byp_load_done),
    .load_err(byp_load_err), .busy(byp_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Scoreboard: every ROM write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rstn && rom_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rom_we", rom_waddr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("rom_waddr", rom_waddr, e[63:32]);
        chk("rom_wdata", rom_wdata, e[31:0]);
        $display("rom write addr=%08h data=%08h", rom_waddr, rom_wdata);
      end
    end
    if (rstn && byp_rom_we) chk("bypass_rom_we", {31'd0, byp_rom_we}, 32'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic pulse_boot_req();
    boot_req = 1'b1;
    @(posedge clk);
    #1;
    boot_req = 1'b0;
  endtask

  task automatic send_good();
    send_byte(8'hA5);
    send_word(32'd2);
    exp_q.push_back({32'h0, 32'h13});
    send_word(32'h13);
    exp_q.push_back({32'h4, 32'h6F});
    send_word(32'h6F);
    send_byte(8'h7E);
  endtask

  typedef struct {
    logic [7:0]  pre;
    logic [31:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    int          nw;
    bit          send_csum;
    logic [7:0]  csum;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];
  bit   prev_err;

  initial begin
    vecs[0] = '{pre:8'h13, len:32'd2, w0:32'h13, w1:32'h6F, nw:2, send_csum:1'b1, csum:8'h7E, exp_done:1'b1, exp_err:1'b0};
    vecs[1] = '{pre:8'h00, len:32'd2, w0:32'h13, w1:32'h6F, nw:2, send_csum:1'b1, csum:8'h7F, exp_done:1'b0, exp_err:1'b1};
    vecs[2] = '{pre:8'h5A, len:32'd2, w0:32'h13, w1:32'h6F, nw:2, send_csum:1'b1, csum:8'h7E, exp_done:1'b1, exp_err:1'b0};
    vecs[3] = '{pre:8'hA4, len:32'd0, w0:32'h0, w1:32'h0, nw:0, send_csum:1'b0, csum:8'h00, exp_done:1'b0, exp_err:1'b1};
    vecs[4] = '{pre:8'hFF, len:32'h1001, w0:32'h0, w1:32'h0, nw:0, send_csum:1'b0, csum:8'h00, exp_done:1'b0, exp_err:1'b1};

    // Reset state
    idle(2);
    chk("rst_rom_we", {31'd0, rom_we}, 32'd0);
    chk("rst_rom_waddr", rom_waddr, 32'd0);
    chk("rst_rom_wdata", rom_wdata, 32'd0);
    chk("rst_core_rstn", {31'd0, core_rstn}, 32'd0);
    chk("rst_flags", {28'd0, load_done, load_err, busy, byp_core_rstn}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("byp_core_rstn_release", {31'd0, byp_core_rstn}, 32'd0);
    idle(1);
    chk("byp_core_rstn_1cyc", {31'd0, byp_core_rstn}, 32'd1);
    chk("byp_outputs", {byp_rom_waddr[29:0], byp_load_err, byp_busy}, 32'd0);
    chk("byp_wdata", byp_rom_wdata, 32'd0);
    chk("byp_load_done", {31'd0, byp_load_done}, 32'd1);

    prev_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse_boot_req();
      chk("boot_req_core_rstn", {31'd0, core_rstn}, 32'd0);
      chk("boot_req_load_done", {31'd0, load_done}, 32'd0);
      chk("boot_req_keeps_err", {31'd0, load_err}, {31'd0, prev_err});
      send_byte(vecs[i].pre);
      chk("pre_byte_ignored", {31'd0, busy}, 32'd0);
      send_byte(8'hA5);
      send_word(vecs[i].len);
      for (int w = 0; w < vecs[i].nw; w++) begin
        logic [31:0] wd;
        wd = (w == 0) ? vecs[i].w0 : vecs[i].w1;
        exp_q.push_back({32'(w * 4), wd});
        send_word(wd);
      end
      if (vecs[i].send_csum) send_byte(vecs[i].csum);
      chk("vec_load_done_entry", {31'd0, load_done}, {31'd0, vecs[i].exp_done});
      chk("vec_core_rstn_entry", {31'd0, core_rstn}, 32'd0);
      idle(1);
      chk("vec_core_rstn", {31'd0, core_rstn}, {31'd0, vecs[i].exp_done});
      chk("vec_load_err", {31'd0, load_err}, {31'd0, vecs[i].exp_err});
      chk("vec_busy", {31'd0, busy}, 32'd0);
      chk("vec_sb_empty", exp_q.size(), 32'd0);
      $display("vector %0d len=%0h done=%0b err=%0b core_rstn=%0b", i, vecs[i].len, load_done, load_err, core_rstn);
      prev_err = vecs[i].exp_err;
    end

    // N = 2**ADDR_WIDTH is accepted; abort after the first word
    pulse_boot_req();
    send_byte(8'hA5);
    send_word(32'h1000);
    chk("n4096_busy", {31'd0, busy}, 32'd1);
    chk("n4096_no_err", {31'd0, load_err}, 32'd0);
    exp_q.push_back({32'h0, 32'h04030201});
    send_word(32'h04030201);
    idle(1);
    pulse_boot_req();
    chk("n4096_abort", {31'd0, busy}, 32'd0);
    $display("length 0x1000 accepted then aborted");

    // boot_req together with rx_valid mid-DATA: byte dropped, back to IDLE
    send_byte(8'hA5);
    send_word(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_data = 8'h33; rx_valid = 1'b1; boot_req = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; boot_req = 1'b0;
    chk("bootreq_rx_idle", {31'd0, busy}, 32'd0);
    send_byte(8'h44);
    idle(1);
    chk("bootreq_rx_still_idle", {31'd0, busy}, 32'd0);
    send_byte(8'hA5);
    send_word(32'd1);
    exp_q.push_back({32'h0, 32'hDDCCBBAA});
    send_word(32'hDDCCBBAA);
    send_byte(8'h01);
    chk("reload_done", {31'd0, load_done}, 32'd1);
    $display("boot_req with rx_valid dropped byte, reload done=%0b", load_done);

    // Timeout: idle after 6 bytes; a byte on the expiry cycle continues
    pulse_boot_req();
    send_byte(8'hA5);
    send_word(32'd2);
    send_byte(8'h13);
    idle(99);
    chk("to_busy_before_expiry", {31'd0, busy}, 32'd1);
    chk("to_no_err_before_expiry", {31'd0, load_err}, 32'd0);
    send_byte(8'h00);
    chk("to_byte_on_expiry_busy", {31'd0, busy}, 32'd1);
    chk("to_byte_on_expiry_err", {31'd0, load_err}, 32'd0);
    idle(99);
    chk("to_busy_99", {31'd0, busy}, 32'd1);
    idle(1);
    chk("to_err", {31'd0, load_err}, 32'd1);
    chk("to_not_busy", {31'd0, busy}, 32'd0);
    idle(1);
    chk("to_err_sticky", {31'd0, load_err}, 32'd1);
    $display("timeout err=%0b", load_err);

    // Reset asserted while the second word is being written
    send_byte(8'hA5);
    send_word(32'd2);
    exp_q.push_back({32'h0, 32'h11111111});
    send_word(32'h11111111);
    send_word(32'h22222222);
    chk("mid_rom_we_pulse", {31'd0, rom_we}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_rom_we", {31'd0, rom_we}, 32'd0);
    chk("async_rom_waddr", rom_waddr, 32'd0);
    chk("async_rom_wdata", rom_wdata, 32'd0);
    chk("async_flags", {29'd0, load_done, load_err, busy}, 32'd0);
    idle(2);
    rstn = 1'b1;
    send_byte(8'h13);
    send_byte(8'h02);
    send_byte(8'h00);
    idle(1);
    chk("post_rst_ignored", {31'd0, busy}, 32'd0);
    send_good();
    idle(1);
    chk("post_rst_load", {30'd0, load_done, core_rstn}, 32'd3);
    $display("reset mid-frame then good load done=%0b core_rstn=%0b", load_done, core_rstn);

    idle(2);
    chk("final_sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
